// File: rtl/lru_controller_pkg.sv
// Shared cache package: set geometry defaults, the age-stamp type and the
// victim-search FSM state encoding.
package lru_controller_pkg;

  localparam int CACHE_E    = 4;
  localparam int SET_SIZE   = CACHE_E;
  localparam int SET_COUNT  = 4;
  localparam int TICK_WIDTH = 32;

  typedef logic [TICK_WIDTH-1:0] tick_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/lru_scan_step.sv
// Single-line LRU compare: a candidate wins on a strictly older stamp, or
// unconditionally when it is an invalid line (which also ends the scan).
module lru_scan_step #(
  parameter int TICK_WIDTH = 32
) (
  input  logic [TICK_WIDTH-1:0] cand_tick,
  input  logic [TICK_WIDTH-1:0] best_tick,
  input  logic                  cand_invalid,
  output logic                  take,
  output logic                  stop
);
  import lru_controller_pkg::*;

  assign stop = cand_invalid;
  assign take = cand_invalid || (cand_tick < best_tick);

endmodule

// File: rtl/lru_controller.sv
// Age-stamp LRU victim selector with a sequential one-line-per-cycle scan.
// Optional macro CACHE_LRU_PREFER_INVALID_EN adds valid bits and prefers invalid lines.
module lru_controller #(
  parameter int SET_SIZE   = lru_controller_pkg::SET_SIZE,
  parameter int SET_COUNT  = lru_controller_pkg::SET_COUNT,
  parameter int TICK_WIDTH = lru_controller_pkg::TICK_WIDTH,
  localparam int LW = (SET_SIZE  > 1) ? $clog2(SET_SIZE)  : 1,
  localparam int SW = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          touch_valid,
  input  logic [SW-1:0] touch_set,
  input  logic [LW-1:0] touch_line,
  input  logic          inv_valid,
  input  logic [SW-1:0] inv_set,
  input  logic [LW-1:0] inv_line,
  input  logic          vreq_valid,
  input  logic [SW-1:0] vreq_set,
  output logic          vreq_ready,
  output logic          vresp_valid,
  output logic [LW-1:0] vresp_line,
  input  logic          vresp_ready
);
  import lru_controller_pkg::*;

  localparam logic [TICK_WIDTH-1:0] TICK_MAX   = '1;
  localparam logic [TICK_WIDTH-1:0] TICK_ONE   = TICK_WIDTH'(1);
  localparam logic [TICK_WIDTH-1:0] TICK_TWO   = TICK_WIDTH'(2);
  localparam logic [TICK_WIDTH-1:0] TICK_THREE = TICK_WIDTH'(3);

  state_e                state_reg, state_next;
  logic [SW-1:0]         set_reg, set_next;
  logic [LW-1:0]         idx_reg, idx_next;
  logic [LW-1:0]         best_reg, best_next;
  logic [TICK_WIDTH-1:0] gtick_reg, gtick_next;
  logic [TICK_WIDTH-1:0] tick_reg  [SET_COUNT][SET_SIZE];
  logic [TICK_WIDTH-1:0] tick_next [SET_COUNT][SET_SIZE];

  logic fill, same, dual, wrap, any_upd, restart, take, stop, cand_invalid;

  assign fill    = (state_reg == RESP) && vresp_ready;
  assign same    = touch_valid && fill && (touch_set == set_reg) && (touch_line == best_reg);
  assign dual    = touch_valid && fill && !same;
  assign any_upd = touch_valid || fill;
  // A dual event consumes two stamps, so it must normalize one step earlier.
  assign wrap    = dual ? (gtick_reg >= TICK_MAX - TICK_ONE) : (gtick_reg == TICK_MAX);
  assign restart = touch_valid && (touch_set == set_reg);

  always_comb begin
    gtick_next = gtick_reg;
    tick_next  = tick_reg;
    if (any_upd) begin
      if (wrap) gtick_next = dual ? TICK_THREE : TICK_TWO;
      else      gtick_next = gtick_reg + (dual ? TICK_TWO : TICK_ONE);
      for (int i = 0; i < SET_COUNT; i++) begin
        for (int j = 0; j < SET_SIZE; j++) begin
          if (wrap) tick_next[i][j] = '0;
          if (fill && set_reg == SW'(i) && best_reg == LW'(j))
            tick_next[i][j] = wrap ? TICK_ONE : gtick_reg;
          else if (touch_valid && touch_set == SW'(i) && touch_line == LW'(j))
            tick_next[i][j] = wrap ? (dual ? TICK_TWO : TICK_ONE)
                                   : (dual ? gtick_reg + TICK_ONE : gtick_reg);
        end
      end
    end
  end

`ifdef CACHE_LRU_PREFER_INVALID_EN
  logic valid_reg  [SET_COUNT][SET_SIZE];
  logic valid_next [SET_COUNT][SET_SIZE];

  // Touch/fill win over a same-cycle invalidation of the same line.
  always_comb begin
    valid_next = valid_reg;
    for (int i = 0; i < SET_COUNT; i++) begin
      for (int j = 0; j < SET_SIZE; j++) begin
        if ((fill && set_reg == SW'(i) && best_reg == LW'(j)) ||
            (touch_valid && touch_set == SW'(i) && touch_line == LW'(j)))
          valid_next[i][j] = 1'b1;
        else if (inv_valid && inv_set == SW'(i) && inv_line == LW'(j))
          valid_next[i][j] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SET_COUNT; i++)
        for (int j = 0; j < SET_SIZE; j++)
          valid_reg[i][j] <= 1'b0;
    end else begin
      valid_reg <= valid_next;
    end
  end

  assign cand_invalid = !valid_reg[set_reg][idx_reg];
`else
  logic unused_inv;
  assign unused_inv   = ^{inv_valid, inv_set, inv_line};
  assign cand_invalid = 1'b0;
`endif

  lru_scan_step #(
    .TICK_WIDTH (TICK_WIDTH)
  ) u_step (
    .cand_tick    (tick_reg[set_reg][idx_reg]),
    .best_tick    (tick_reg[set_reg][best_reg]),
    .cand_invalid (cand_invalid),
    .take         (take),
    .stop         (stop)
  );

  always_comb begin
    state_next = state_reg;
    set_next   = set_reg;
    idx_next   = idx_reg;
    best_next  = best_reg;
    case (state_reg)
      IDLE: begin
        if (vreq_valid) begin
          set_next   = vreq_set;
          idx_next   = '0;
          best_next  = '0;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (restart) begin
          idx_next  = '0;
          best_next = '0;
        end else begin
          if (take) best_next = idx_reg;
          if (stop || idx_reg == LW'(SET_SIZE - 1)) state_next = RESP;
          else                                      idx_next   = idx_reg + LW'(1);
        end
      end
      RESP: begin
        if (vresp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      set_reg   <= '0;
      idx_reg   <= '0;
      best_reg  <= '0;
      gtick_reg <= TICK_ONE;
      for (int i = 0; i < SET_COUNT; i++)
        for (int j = 0; j < SET_SIZE; j++)
          tick_reg[i][j] <= '0;
    end else begin
      state_reg <= state_next;
      set_reg   <= set_next;
      idx_reg   <= idx_next;
      best_reg  <= best_next;
      gtick_reg <= gtick_next;
      tick_reg  <= tick_next;
    end
  end

  assign vreq_ready  = (state_reg == IDLE);
  assign vresp_valid = (state_reg == RESP);
  assign vresp_line  = best_reg;

endmodule

// File: tb/tb_lru_controller.sv
// Scoreboard bench for lru_controller: directed touches/requests, a queue of
// expected victims, and a monitor that checks each new victim response.
module tb_lru_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       touch_valid = 1'b0;
  logic [1:0] touch_set = 2'd0;
  logic [1:0] touch_line = 2'd0;
  logic       inv_valid = 1'b0;
  logic [1:0] inv_set = 2'd0;
  logic [1:0] inv_line = 2'd0;
  logic       vreq_valid = 1'b0;
  logic [1:0] vreq_set = 2'd0;
  logic       vreq_ready;
  logic       vresp_valid;
  logic [1:0] vresp_line;
  logic       vresp_ready = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_q[$];
  logic prev_valid = 1'b0;

  lru_controller #(
    .SET_SIZE   (4),
    .SET_COUNT  (4),
    .TICK_WIDTH (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .touch_valid (touch_valid),
    .touch_set   (touch_set),
    .touch_line  (touch_line),
    .inv_valid   (inv_valid),
    .inv_set     (inv_set),
    .inv_line    (inv_line),
    .vreq_valid  (vreq_valid),
    .vreq_set    (vreq_set),
    .vreq_ready  (vreq_ready),
    .vresp_valid (vresp_valid),
    .vresp_line  (vresp_line),
    .vresp_ready (vresp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end else begin
      $display("[TB] ok %s = %0d", name, actual);
    end
  endtask

  // Monitor: each new victim response is matched against the scoreboard.
  always @(negedge clk) begin
    if (vresp_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_resp: got line %0d, expected no response", int'(vresp_line));
      end else begin
        check("vresp_line", int'(vresp_line), exp_q.pop_front());
      end
    end
    prev_valid <= vresp_valid;
  end

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_vreq_ready", int'(vreq_ready), 1);
    check("rst_vresp_valid", int'(vresp_valid), 0);
    check("rst_vresp_line", int'(vresp_line), 0);
    check("rst_gtick", int'(dut.gtick_reg), 1);
  endtask

  task automatic touch(input int s, input int l);
    touch_valid = 1'b1;
    touch_set   = 2'(s);
    touch_line  = 2'(l);
    @(negedge clk);
    touch_valid = 1'b0;
  endtask

  // Latency counts cycles from the handshake cycle to the first vresp_valid cycle.
  task automatic request(input int s, input int exp_line, input int exp_lat,
                         input int touch_at, input int ts, input int tl);
    int cnt;
    check("vreq_ready_idle", int'(vreq_ready), 1);
    exp_q.push_back(exp_line);
    vreq_valid = 1'b1;
    vreq_set   = 2'(s);
    @(negedge clk);
    vreq_valid = 1'b0;
    cnt = 1;
    while (!vresp_valid && cnt < 40) begin
      if (cnt == touch_at) begin
        touch_valid = 1'b1;
        touch_set   = 2'(ts);
        touch_line  = 2'(tl);
      end
      @(negedge clk);
      touch_valid = 1'b0;
      cnt++;
    end
    check("resp_latency", cnt, exp_lat);
  endtask

  task automatic respond(input int line, input int hold, input int t_en,
                         input int ts, input int tl);
    for (int i = 0; i < hold; i++) begin
      check("hold_line", int'(vresp_line), line);
      check("hold_vreq_ready", int'(vreq_ready), 0);
      @(negedge clk);
    end
    vresp_ready = 1'b1;
    if (t_en != 0) begin
      touch_valid = 1'b1;
      touch_set   = 2'(ts);
      touch_line  = 2'(tl);
    end
    @(negedge clk);
    vresp_ready = 1'b0;
    touch_valid = 1'b0;
    check("idle_after_resp", int'(vreq_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Sequential touches: line 0 is oldest.
    for (int l = 0; l < 4; l++) touch(0, l);
    request(0, 0, 5, 0, 0, 0);
    respond(0, 0, 0, 0, 0);
    check("gtick_after_fill", int'(dut.gtick_reg), 6);

    // Touch order 2,0,3,1 then fills, dual events and a held response.
    do_reset();
    touch(1, 2); touch(1, 0); touch(1, 3); touch(1, 1);
    request(1, 2, 5, 0, 0, 0);
    respond(2, 0, 0, 0, 0);
    request(1, 0, 5, 0, 0, 0);
    respond(0, 0, 1, 1, 3);
    check("gtick_dual_diff", int'(dut.gtick_reg), 8);
    request(1, 1, 5, 0, 0, 0);
    respond(1, 0, 1, 1, 1);
    check("gtick_dual_same", int'(dut.gtick_reg), 9);
    request(1, 2, 5, 0, 0, 0);
    respond(2, 10, 0, 0, 0);
    check("gtick_after_hold", int'(dut.gtick_reg), 10);

    // Touch to the scanned set restarts the scan.
    do_reset();
    for (int l = 0; l < 4; l++) touch(0, l);
    request(0, 0, 7, 2, 0, 1);
    respond(0, 0, 0, 0, 0);

    // Wrap normalization.
    do_reset();
    touch(0, 0); touch(0, 1); touch(0, 2);
    for (int k = 0; k < 11; k++) touch(2, 0);
    check("gtick_pre_wrap", int'(dut.gtick_reg), 15);
    touch(0, 3);
    check("gtick_post_wrap", int'(dut.gtick_reg), 2);
    request(0, 0, 5, 0, 0, 0);
    respond(0, 0, 0, 0, 0);
    request(2, 0, 5, 0, 0, 0);
    respond(0, 0, 0, 0, 0);
    request(0, 1, 5, 0, 0, 0);
    respond(1, 0, 0, 0, 0);

    // Reset while in RESP abandons the request.
    do_reset();
    touch(3, 1);
    request(3, 0, 5, 0, 0, 0);
    reset = 1'b1;
    vresp_ready = 1'b1;
    @(negedge clk);
    vresp_ready = 1'b0;
    check("rst_in_resp_valid", int'(vresp_valid), 0);
    check("rst_in_resp_ready", int'(vreq_ready), 1);
    check("rst_in_resp_gtick", int'(dut.gtick_reg), 1);
    reset = 1'b0;
    @(negedge clk);

`ifdef CACHE_LRU_PREFER_INVALID_EN
    do_reset();
    request(0, 0, 2, 0, 0, 0);
    respond(0, 0, 0, 0, 0);
    do_reset();
    for (int l = 0; l < 4; l++) touch(0, l);
    inv_valid = 1'b1; inv_set = 2'd0; inv_line = 2'd2;
    @(negedge clk);
    inv_valid = 1'b0;
    request(0, 2, 4, 0, 0, 0);
    respond(2, 0, 0, 0, 0);
`else
    do_reset();
    for (int l = 0; l < 4; l++) touch(0, l);
    inv_valid = 1'b1; inv_set = 2'd0; inv_line = 2'd2;
    @(negedge clk);
    inv_valid = 1'b0;
    request(0, 0, 5, 0, 0, 0);
    respond(0, 0, 0, 0, 0);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
